// File: rtl/weight_preload_fifo.sv
// weight_preload_fifo
//   AXI4-Stream slave that packs AXIS_DATA_WIDTH-bit weight beats into
//   (5*MAC_NUM)-bit weight words. Packed words go into a first-word-fall-through
//   FIFO that the BRAM weight-write controller reads.
//   Optional build macro WEIGHT_PRELOAD_TLAST_CHECK_EN: tlast on an early beat
//   commits a zero-padded partial word and sets the sticky tlast_err flag.
module weight_preload_fifo #(
   parameter int MAC_NUM         = 256,
   parameter int AXIS_DATA_WIDTH = 64,
   parameter int FIFO_DEPTH      = 4,
   localparam int WW    = 5 * MAC_NUM,
   localparam int ADW   = AXIS_DATA_WIDTH,
   localparam int BEATS = (WW + ADW - 1) / ADW,
   localparam int CNT_W = $clog2(FIFO_DEPTH),
   localparam int PTR_W = $clog2(FIFO_DEPTH),
   localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [ADW-1:0]   s_axis_tdata,
   input  logic             s_axis_tvalid,
   input  logic             s_axis_tlast,
   output logic             s_axis_tready,
   input  logic             layer_finish,
   input  logic             axis_fifo_read,
   output logic [WW-1:0]    weight_from_preload,
   output logic [CNT_W:0]   axis_fifo_cnt,
   output logic             wait_weight_preload,
   output logic             tlast_err
);

   localparam logic [CNT_W:0] FULL_CNT  = (CNT_W+1)'(FIFO_DEPTH);
   localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);

   logic [BC_W-1:0]                beat_cnt_q, beat_cnt_d;
   logic [BEATS*ADW-1:0]           pack_q, pack_d;
   logic [BEATS*ADW-1:0]           merged;
   logic [FIFO_DEPTH-1:0][WW-1:0]  mem_q;
   logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W:0]                 cnt_q, cnt_d;
   logic                           rdy_en_q;
   logic                           last_beat, full, hs, commit, pop;

   assign last_beat = (beat_cnt_q == LAST_BEAT);
   assign full      = (cnt_q == FULL_CNT);
   // A dropped beat under layer_finish is not a handshake for the packer.
   assign hs        = s_axis_tvalid & s_axis_tready & ~layer_finish;
   assign pop       = axis_fifo_read & (cnt_q != '0) & ~layer_finish;

`ifdef WEIGHT_PRELOAD_TLAST_CHECK_EN
   logic tlast_err_q;
   // Any beat may commit, so stall whenever there is no room for a word.
   assign s_axis_tready = rdy_en_q & ~full;
   assign commit        = hs & (last_beat | s_axis_tlast);
   assign tlast_err     = tlast_err_q;

   // Sticky flag for a block that ended mid-word; only rst_n clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                tlast_err_q <= 1'b0;
      else if (hs && s_axis_tlast && !last_beat) tlast_err_q <= 1'b1;
   end
`else
   logic unused_tlast;
   assign unused_tlast  = s_axis_tlast;
   // Only the committing beat waits for FIFO space; earlier beats land in the pack register.
   assign s_axis_tready = rdy_en_q & ~(last_beat & full);
   assign commit        = hs & last_beat;
   assign tlast_err     = 1'b0;
`endif

   assign weight_from_preload = mem_q[rd_ptr_q];
   assign axis_fifo_cnt       = cnt_q;
   assign wait_weight_preload = (cnt_q != '0);

   // Pack register with the current beat dropped into its slot; the commit word.
   always_comb begin
      merged = pack_q;
      merged[beat_cnt_q*ADW +: ADW] = s_axis_tdata;
   end

   // Next-state for packer, pointers and word count.
   always_comb begin
      beat_cnt_d = beat_cnt_q;
      pack_d     = pack_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      if (layer_finish) begin
         beat_cnt_d = '0;
         pack_d     = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         cnt_d      = '0;
      end else begin
         if (commit) begin
            // Clearing on commit keeps slots above a short word zero.
            beat_cnt_d = '0;
            pack_d     = '0;
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
         end else if (hs) begin
            beat_cnt_d = beat_cnt_q + BC_W'(1);
            pack_d     = merged;
         end
         if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({commit, pop})
            2'b10:   cnt_d = cnt_q + (CNT_W+1)'(1);
            2'b01:   cnt_d = cnt_q - (CNT_W+1)'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Control and packer state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt_q <= '0;
         pack_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         rdy_en_q   <= 1'b0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         pack_q     <= pack_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         rdy_en_q   <= 1'b1;
      end
   end

   // Word storage; reset so the head reads zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      mem_q <= '0;
      else if (commit) mem_q[wr_ptr_q] <= merged[WW-1:0];
   end

endmodule

// File: tb/tb_weight_preload_fifo.sv
// Bench for weight_preload_fifo: table-driven first word, hand sequences for
// back-pressure, simultaneous push/pop, underflow, flush and (optionally) early
// tlast, then random traffic checked against a queue-based reference model.
module tb_weight_preload_fifo;
   localparam int ADW = 64, WW = 1280, BEATS = 20, DEPTH = 4;
`ifdef WEIGHT_PRELOAD_TLAST_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic            clk = 1'b0, rst_n = 1'b0;
   logic [ADW-1:0]  s_axis_tdata = '0;
   logic            s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
   logic            layer_finish = 1'b0, axis_fifo_read = 1'b0;
   logic [WW-1:0]   weight_from_preload;
   logic [2:0]      axis_fifo_cnt;
   logic            wait_weight_preload, tlast_err;

   weight_preload_fifo dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .layer_finish(layer_finish), .axis_fifo_read(axis_fifo_read),
      .weight_from_preload(weight_from_preload), .axis_fifo_cnt(axis_fifo_cnt),
      .wait_weight_preload(wait_weight_preload), .tlast_err(tlast_err)
   );

   always #5 clk = ~clk;

   int errors = 0, checks = 0;

   // reference model: queue of committed words plus beats of the word in progress
   logic [WW-1:0]        mq[$];
   logic [BEATS*ADW-1:0] part;
   int                   nb;
   bit                   merr;

   typedef struct {
      logic            v;
      logic [ADW-1:0]  d;
      logic            rd;
      logic            exp_rdy;
      logic [2:0]      exp_cnt;
   } vec_t;
   vec_t tbl[BEATS];

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   task automatic chk_word(input string n, input logic [WW-1:0] a, input logic [WW-1:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         for (int i = 0; i < WW/ADW; i++)
            if (a[i*ADW +: ADW] !== e[i*ADW +: ADW]) begin
               $display("FAIL %s: chunk %0d got %h expected %h", n, i, a[i*ADW +: ADW], e[i*ADW +: ADW]);
               break;
            end
      end
   endtask

   function automatic logic [ADW-1:0] mk(input int b, input int k);
      return {32'(b), 32'(k)};
   endfunction

   function automatic logic [WW-1:0] mkword(input int b);
      logic [WW-1:0] w;
      for (int k = 0; k < BEATS; k++) w[k*ADW +: ADW] = mk(b, k);
      return w;
   endfunction

   // One clock: drive, check tready, advance model, clock, check outputs.
   task automatic step(input logic v, input logic [ADW-1:0] d, input logic l,
                       input logic rd, input logic lf, output logic rdy_seen);
      bit rdy_exp, acc;
      s_axis_tvalid = v; s_axis_tdata = d; s_axis_tlast = l;
      axis_fifo_read = rd; layer_finish = lf;
      #2;
      rdy_exp  = CHK_EN ? (mq.size() < DEPTH) : !(nb == BEATS-1 && mq.size() == DEPTH);
      rdy_seen = s_axis_tready;
      chk("tready", 64'(s_axis_tready), 64'(rdy_exp));
      acc = v && rdy_exp;
      if (lf) begin
         mq.delete(); part = '0; nb = 0;
      end else begin
         if (rd && mq.size() > 0) void'(mq.pop_front());
         if (acc) begin
            part[nb*ADW +: ADW] = d;
            nb++;
            if (nb == BEATS || (CHK_EN && l)) begin
               if (nb != BEATS) merr = 1'b1;
               mq.push_back(part[WW-1:0]);
               part = '0; nb = 0;
            end
         end
      end
      @(posedge clk); #1;
      chk("cnt",  64'(axis_fifo_cnt), 64'(mq.size()));
      chk("wait", 64'(wait_weight_preload), 64'(mq.size() != 0));
      chk("tlast_err", 64'(tlast_err), 64'(merr));
      if (mq.size() > 0) chk_word("head", weight_from_preload, mq[0]);
   endtask

   task automatic send_word(input int b, input bit rd_last);
      logic r;
      for (int k = 0; k < BEATS; k++) step(1'b1, mk(b, k), 1'b0, rd_last && k == BEATS-1, 1'b0, r);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tlast = 0;
      axis_fifo_read = 0; layer_finish = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tready", 64'(s_axis_tready), 64'd0);
      chk("rst_cnt", 64'(axis_fifo_cnt), 64'd0);
      chk("rst_wait", 64'(wait_weight_preload), 64'd0);
      chk("rst_err", 64'(tlast_err), 64'd0);
      chk_word("rst_head", weight_from_preload, '0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      mq.delete(); part = '0; nb = 0; merr = 1'b0;
   endtask

   initial begin
      logic r;
      // 1: first word, table-driven
      for (int k = 0; k < BEATS; k++) begin
         tbl[k].v = 1'b1; tbl[k].d = 64'(k); tbl[k].rd = 1'b0;
         tbl[k].exp_rdy = 1'b1; tbl[k].exp_cnt = (k == BEATS-1) ? 3'd1 : 3'd0;
      end
      do_reset();
      for (int k = 0; k < BEATS; k++) begin
         step(tbl[k].v, tbl[k].d, 1'b0, tbl[k].rd, 1'b0, r);
         chk("t1_rdy", 64'(r), 64'(tbl[k].exp_rdy));
         chk("t1_cnt", 64'(axis_fifo_cnt), 64'(tbl[k].exp_cnt));
      end
      chk("t1_wait", 64'(wait_weight_preload), 64'd1);
      for (int k = 0; k < BEATS; k++)
         chk("t1_word", weight_from_preload[k*ADW +: ADW], 64'(k));

      // 2: full FIFO stalls only the committing beat
      do_reset();
      for (int w = 0; w < 4; w++) send_word(100 + w, 1'b0);
      chk("t2_full", 64'(axis_fifo_cnt), 64'd4);
      for (int k = 0; k < BEATS-1; k++) begin
         step(1'b1, mk(104, k), 1'b0, 1'b0, 1'b0, r);
         chk("t2_mid_rdy", 64'(r), 64'd1);
      end
      step(1'b1, mk(104, 19), 1'b0, 1'b0, 1'b0, r);
      chk("t2_stall", 64'(r), 64'd0);
      step(1'b1, mk(104, 19), 1'b0, 1'b1, 1'b0, r);
      chk("t2_no_comb_ready", 64'(r), 64'd0);
      chk("t2_cnt_pop", 64'(axis_fifo_cnt), 64'd3);
      step(1'b1, mk(104, 19), 1'b0, 1'b0, 1'b0, r);
      chk("t2_accept", 64'(r), 64'd1);
      chk("t2_cnt_back", 64'(axis_fifo_cnt), 64'd4);
      chk_word("t2_head", weight_from_preload, mkword(101));

      // 3: simultaneous commit and pop, pointer wrap
      do_reset();
      send_word(200, 1'b0);
      send_word(201, 1'b0);
      send_word(202, 1'b1);
      chk("t3_cnt", 64'(axis_fifo_cnt), 64'd2);
      chk_word("t3_head2", weight_from_preload, mkword(201));
      step(1'b0, '0, 1'b0, 1'b1, 1'b0, r);
      chk_word("t3_head3", weight_from_preload, mkword(202));
      for (int i = 0; i < 12; i++) begin
         send_word(300 + i, 1'b1);
         chk("t3_wrap_cnt", 64'(axis_fifo_cnt), 64'd1);
         chk_word("t3_wrap_head", weight_from_preload, mkword(300 + i));
      end

      // 4: reads on an empty FIFO are ignored
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b0, '0, 1'b0, 1'b1, 1'b0, r);
         chk("t4_empty", 64'(axis_fifo_cnt), 64'd0);
      end
      send_word(400, 1'b0);
      chk("t4_cnt", 64'(axis_fifo_cnt), 64'd1);
      chk_word("t4_head", weight_from_preload, mkword(400));

      // 5: layer_finish mid-word flushes everything; beat in that cycle is dropped
      do_reset();
      for (int w = 0; w < 3; w++) send_word(500 + w, 1'b0);
      for (int k = 0; k < 7; k++) step(1'b1, mk(503, k), 1'b0, 1'b0, 1'b0, r);
      step(1'b1, mk(503, 7), 1'b0, 1'b0, 1'b1, r);
      chk("t5_cnt", 64'(axis_fifo_cnt), 64'd0);
      chk("t5_wait", 64'(wait_weight_preload), 64'd0);
      send_word(600, 1'b0);
      chk("t5_cnt1", 64'(axis_fifo_cnt), 64'd1);
      chk_word("t5_head", weight_from_preload, mkword(600));

`ifdef WEIGHT_PRELOAD_TLAST_CHECK_EN
      // 6: early tlast commits a zero-padded partial word
      begin
         logic [WW-1:0] exp6;
         logic [ADW-1:0] a5;
         a5 = {8{8'hA5}};
         do_reset();
         exp6 = '0;
         for (int k = 0; k < 5; k++) begin
            step(1'b1, (k == 4) ? a5 : mk(700, k), k == 4, 1'b0, 1'b0, r);
            exp6[k*ADW +: ADW] = (k == 4) ? a5 : mk(700, k);
         end
         chk("t6_cnt", 64'(axis_fifo_cnt), 64'd1);
         chk("t6_err", 64'(tlast_err), 64'd1);
         chk_word("t6_word", weight_from_preload, exp6);
         send_word(701, 1'b0);
         step(1'b0, '0, 1'b0, 1'b1, 1'b0, r);
         chk("t6_next_lsb", weight_from_preload[ADW-1:0], mk(701, 0));
      end
`endif

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++)
         step(($urandom % 4) != 0, {$urandom, $urandom}, ($urandom % 16) == 0,
              ($urandom % 3) == 0, ($urandom % 200) == 0, r);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
